status_flags: RTL and testbench

Processor status (P) register stage sitting directly downstream of the `alu` block: captures the ALU's carry/overflow/zero/negative outputs under per-instruction update masks, executes flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), handles BIT, PLP/RTI loads and PHP/BRK push formatting. It also gates the maskable interrupt request with the 6502 one-instruction I-flag latency. The carry output feeds back to the ALU's `carry_in`.

---
 rtl/status_flags.sv | 128 ++++++++++++
 tb/tb_status_flags.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/status_flags.sv
// 6502 processor status register with masked ALU capture, flag ops, BIT, PLP/RTI loads and IRQ gating.
// Optional D flag storage is enabled by defining STATUS_DECIMAL_EN.
module status_flags (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_c,
   input  logic       alu_v,
   input  logic       alu_z,
   input  logic       alu_n,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       bit_op,
   input  logic [7:0] mem_in,
   input  logic       load_p,
   input  logic       rti,
   input  logic       flag_op_en,
   input  logic [2:0] flag_op,
   input  logic       instr_done,
   input  logic       irq_line,
   input  logic       brk_push,
   output logic [7:0] p_out,
   output logic [7:0] p_push,
   output logic       carry_out,
   output logic       decimal_mode,
   output logic       irq_req
);

   logic r_n, r_v, r_i, r_z, r_c;
   logic r_i_eff, r_irq_req;
   logic w_n_next, w_v_next, w_i_next, w_z_next, w_c_next;
   logic w_d;
   logic w_unused;

`ifdef STATUS_DECIMAL_EN
   logic r_d;
   logic w_d_next;
   assign w_d      = r_d;
   assign w_unused = ^mem_in[5:4];
`else
   assign w_d      = 1'b0;
   assign w_unused = ^mem_in[5:3];
`endif

   // Sources applied lowest priority first so later writes win bit by bit.
   always_comb begin
      w_n_next = r_n;
      w_v_next = r_v;
      w_i_next = r_i;
      w_z_next = r_z;
      w_c_next = r_c;
`ifdef STATUS_DECIMAL_EN
      w_d_next = r_d;
`endif
      if (upd_nz) begin
         w_n_next = alu_n;
         w_z_next = alu_z;
      end
      if (upd_c) w_c_next = alu_c;
      if (upd_v) w_v_next = alu_v;
      if (bit_op) begin
         w_n_next = mem_in[7];
         w_v_next = mem_in[6];
         w_z_next = alu_z;
      end
      if (flag_op_en) begin
         case (flag_op)
            3'd0: w_c_next = 1'b0;
            3'd1: w_c_next = 1'b1;
            3'd2: w_i_next = 1'b0;
            3'd3: w_i_next = 1'b1;
            3'd4: w_v_next = 1'b0;
`ifdef STATUS_DECIMAL_EN
            3'd5: w_d_next = 1'b0;
            3'd6: w_d_next = 1'b1;
`endif
            default: ;
         endcase
      end
      if (load_p) begin
         w_n_next = mem_in[7];
         w_v_next = mem_in[6];
         w_i_next = mem_in[2];
         w_z_next = mem_in[1];
         w_c_next = mem_in[0];
`ifdef STATUS_DECIMAL_EN
         w_d_next = mem_in[3];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n       <= 1'b0;
         r_v       <= 1'b0;
         r_i       <= 1'b1;
         r_z       <= 1'b0;
         r_c       <= 1'b0;
         r_i_eff   <= 1'b1;
         r_irq_req <= 1'b0;
`ifdef STATUS_DECIMAL_EN
         r_d       <= 1'b0;
`endif
      end else begin
         r_n       <= w_n_next;
         r_v       <= w_v_next;
         r_i       <= w_i_next;
         r_z       <= w_z_next;
         r_c       <= w_c_next;
`ifdef STATUS_DECIMAL_EN
         r_d       <= w_d_next;
`endif
         // RTI unmasks at once; everything else lags by one instruction boundary.
         if (load_p && rti)
            r_i_eff <= mem_in[2];
         else if (instr_done)
            r_i_eff <= r_i;
         r_irq_req <= irq_line & ~r_i_eff;
      end
   end

   assign p_out        = {r_n, r_v, 2'b11, w_d, r_i, r_z, r_c};
   assign p_push       = {r_n, r_v, 1'b1, brk_push, w_d, r_i, r_z, r_c};
   assign carry_out    = r_c;
   assign decimal_mode = w_d;
   assign irq_req      = r_irq_req;

endmodule

// File: tb/tb_status_flags.sv
// Table-driven bench for status_flags plus hand sequences for IRQ latency and reset corners.
module tb_status_flags;

`ifdef STATUS_DECIMAL_EN
   localparam logic DEN = 1'b1;
`else
   localparam logic DEN = 1'b0;
`endif
   localparam logic [7:0] DMASK = DEN ? 8'hFF : 8'hF7;

   logic clk = 1'b0;
   logic rst;
   logic alu_c, alu_v, alu_z, alu_n;
   logic upd_nz, upd_c, upd_v, bit_op;
   logic [7:0] mem_in;
   logic load_p, rti, flag_op_en;
   logic [2:0] flag_op;
   logic instr_done, irq_line, brk_push;
   logic [7:0] p_out, p_push;
   logic carry_out, decimal_mode, irq_req;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   status_flags dut (
      .clk(clk), .rst(rst),
      .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
      .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op),
      .mem_in(mem_in), .load_p(load_p), .rti(rti),
      .flag_op_en(flag_op_en), .flag_op(flag_op),
      .instr_done(instr_done), .irq_line(irq_line), .brk_push(brk_push),
      .p_out(p_out), .p_push(p_push), .carry_out(carry_out),
      .decimal_mode(decimal_mode), .irq_req(irq_req)
   );

   typedef struct {
      logic       upd_nz, upd_c, upd_v, bit_op, load_p, fen;
      logic [2:0] fop;
      logic       n, z, c, v, brk;
      logic [7:0] mem;
      logic [7:0] exp_p;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      {alu_c, alu_v, alu_z, alu_n} = 4'b0;
      {upd_nz, upd_c, upd_v, bit_op} = 4'b0;
      mem_in = 8'h00;
      {load_p, rti, flag_op_en} = 3'b0;
      flag_op = 3'd7;
      {instr_done, brk_push} = 2'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      //          nz    c     v     bit   ld    fen   fop   n     z     c     v     brk   mem    exp
      vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,3'd7,1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,8'hF5};
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,3'd7,1'b0,1'b1,1'b0,1'b0,1'b1,8'h40,8'h76};
      vecs[2]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,1'b1,1'b0,8'h80,8'hB4};
      vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'hB5};
      vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,3'd4,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,8'hB4};
      vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd6,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'hBC};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,3'd5,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,8'h36};
      vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd7,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'h36};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hCF,8'hFF};
      vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,3'd1,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'h30};
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h31};
      vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,3'd0,1'b0,1'b0,1'b1,1'b0,1'b1,8'h00,8'h30};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd3,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h34};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,8'h30};
      vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,3'd7,1'b0,1'b0,1'b1,1'b0,1'b0,8'h30,8'h30};
      vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,3'd6,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,8'h3A};

      clear_inputs();
      irq_line = 1'b1;
      do_reset();

      // Reset state, with irq_line held high throughout
      chk("reset_p_out", p_out, 8'h34);
      chk("reset_irq", {7'b0, irq_req}, 8'h00);
      chk("reset_carry", {7'b0, carry_out}, 8'h00);
      chk("reset_dec", {7'b0, decimal_mode}, 8'h00);
      brk_push = 1'b1;
      #1;
      chk("reset_php_brk", p_push, 8'h34);
      brk_push = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("reset_irq_held", {7'b0, irq_req}, 8'h00);
      end
      irq_line = 1'b0;

      // Table: each vector applied for one edge, state carries forward
      for (int k = 0; k < 16; k++) begin
         logic [7:0] e;
         upd_nz = vecs[k].upd_nz; upd_c = vecs[k].upd_c; upd_v = vecs[k].upd_v;
         bit_op = vecs[k].bit_op; load_p = vecs[k].load_p;
         flag_op_en = vecs[k].fen; flag_op = vecs[k].fop;
         alu_n = vecs[k].n; alu_z = vecs[k].z; alu_c = vecs[k].c; alu_v = vecs[k].v;
         brk_push = vecs[k].brk; mem_in = vecs[k].mem;
         tick();
         e = vecs[k].exp_p & DMASK;
         chk($sformatf("vec%0d_p_out", k), p_out, e);
         chk($sformatf("vec%0d_p_push", k), p_push, {e[7:5], vecs[k].brk, e[3:0]});
         chk($sformatf("vec%0d_carry", k), {7'b0, carry_out}, {7'b0, e[0]});
         chk($sformatf("vec%0d_dec", k), {7'b0, decimal_mode}, {7'b0, e[3]});
         chk($sformatf("vec%0d_irq", k), {7'b0, irq_req}, 8'h00);
      end

      // CLI coincident with instr_done: i_eff only clears at the next boundary
      clear_inputs();
      irq_line = 1'b1;
      do_reset();
      flag_op_en = 1'b1; flag_op = 3'd2; instr_done = 1'b1;
      tick();
      chk("cli_p_out", p_out, 8'h30);
      chk("cli_irq_0", {7'b0, irq_req}, 8'h00);
      clear_inputs();
      tick();
      chk("cli_irq_1", {7'b0, irq_req}, 8'h00);
      instr_done = 1'b1;
      tick();
      chk("cli_irq_done2", {7'b0, irq_req}, 8'h00);
      instr_done = 1'b0;
      tick();
      chk("cli_irq_rise", {7'b0, irq_req}, 8'h01);
      flag_op_en = 1'b1; flag_op = 3'd3;
      tick();
      chk("sei_irq_still", {7'b0, irq_req}, 8'h01);
      clear_inputs();
      instr_done = 1'b1;
      tick();
      chk("sei_irq_done", {7'b0, irq_req}, 8'h01);
      instr_done = 1'b0;
      tick();
      chk("sei_irq_masked", {7'b0, irq_req}, 8'h00);

      // PLP without rti does not touch i_eff
      do_reset();
      load_p = 1'b1; mem_in = 8'h00;
      tick();
      clear_inputs();
      chk("plp_p_out", p_out, 8'h30);
      tick();
      chk("plp_irq_masked", {7'b0, irq_req}, 8'h00);

      // RTI: I reaches i_eff in the same edge
      do_reset();
      load_p = 1'b1; rti = 1'b1; mem_in = 8'hFB;
      tick();
      clear_inputs();
      chk("rti_p_out", p_out, 8'hFB & DMASK);
      chk("rti_irq_0", {7'b0, irq_req}, 8'h00);
      tick();
      chk("rti_irq_1", {7'b0, irq_req}, 8'h01);
      irq_line = 1'b0;
      tick();
      chk("rti_irq_drop", {7'b0, irq_req}, 8'h00);

      // Reset wins over a simultaneous load and flag op
      irq_line = 1'b1;
      rst = 1'b1; load_p = 1'b1; rti = 1'b1; mem_in = 8'h00;
      flag_op_en = 1'b1; flag_op = 3'd1;
      tick();
      rst = 1'b0;
      clear_inputs();
      chk("midrst_p_out", p_out, 8'h34);
      chk("midrst_irq", {7'b0, irq_req}, 8'h00);
      tick();
      chk("midrst_irq_after", {7'b0, irq_req}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
